quad_decoder_ctrl: RTL and testbench
====================================

Name: quad_decoder_ctrl

Overview:
- Quadrature-encoder front end that produces the control strobes for the 16-bit up/down counter: count_enb, updn_cnt, and an active-low ld_cnt with a preset value.
- Synchronises and glitch-filters the raw A/B/index encoder pins, decodes Gray-code transitions into direction pulses, and flags illegal transitions.
- Sits between the board encoder pins and the counter's control/data inputs.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in the synchroniser per input; legal range 2..4.
- FILT_CYCLES, 3, consecutive stable cycles required before a filtered input accepts a new level; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- quad_a  input  1  raw encoder channel A, asynchronous.
- quad_b  input  1  raw encoder channel B, asynchronous.
- quad_idx  input  1  raw encoder index pulse, asynchronous.
- idx_enb  input  1  1 = index-triggered preset load enabled.
- preset  input  16  value presented to the counter on load.
- count_enb  output  1  one-cycle count strobe.
- updn_cnt  output  1  direction: 1 = up (A leads B), 0 = down; held between strobes.
- ld_cnt  output  1  active-low one-cycle load strobe.
- data_in  output  16  registered copy of preset, captured on the load cycle.
- err  output  1  sticky illegal-transition flag; cleared only by rst.
- err_cnt  output  8  illegal-transition count, saturates at 255.

Behaviour:
- Reset values, on posedge clk with rst=1:
  - count_enb=0, updn_cnt=1, ld_cnt=1, data_in=0, err=0, err_cnt=0.
  - Synchroniser and filter registers = 0; filter counters = 0; primed=0.
- Reset mid-operation: the same values apply on the next edge; any pending strobe is dropped.
- Input path, per channel:
  - SYNC_STAGES-deep synchroniser, then a glitch filter.
  - Filter: when the synced value differs from the filtered value, the counter increments; otherwise the counter clears.
  - When the counter reaches FILT_CYCLES, the filtered value takes the synced value and the counter clears.
  - A pulse shorter than FILT_CYCLES cycles never reaches the filtered value.
- Latency: a clean edge on quad_a/quad_b produces a count_enb pulse exactly SYNC_STAGES+FILT_CYCLES+1 clk edges after first sampling (default 6).
- Decode state machine on filtered {A,B}, with states Q00, Q01, Q11, Q10:
  - Forward order Q00->Q10->Q11->Q01->Q00: count_enb=1 for one cycle, updn_cnt=1.
  - Reverse order: count_enb=1 for one cycle, updn_cnt=0.
  - No change: count_enb=0.
  - Both bits change in the same cycle (illegal): count_enb=0, err set, err_cnt increments unless already 255; the state still moves to the new value.
- Priming: after reset, primed=0. The first time both A and B filters have been stable FILT_CYCLES cycles, the decoder adopts the current {A,B} silently, with no count and no error, and sets primed=1. Before primed=1, no strobes are issued.
- Index load:
  - Fires on a rising edge of filtered idx when idx_enb=1, primed=1 and the decoder state is Q00.
  - ld_cnt=0 for exactly one cycle, and data_in<=preset on the same edge.
  - Index rising edge in any other state: ignored.
- Simultaneous load and count: the load wins; count_enb is forced to 0 that cycle and the movement is lost. This matches the counter's load-over-count priority.
- Width rules: filter counters are $clog2(FILT_CYCLES+1) bits; err_cnt saturates and never wraps.
- One transition per filtered update; the maximum count rate is therefore bounded by FILT_CYCLES and is not otherwise limited.

Decomposition:
- Shared package quad_pkg:
  - typedef enum logic [1:0] quad_state_t {Q00=2'b00, Q01=2'b01, Q11=2'b11, Q10=2'b10}.
  - Constants DIR_UP=1'b1, DIR_DN=1'b0, ERR_CNT_MAX=8'hFF.
- Sub-module quad_input_filter (params SYNC_STAGES, FILT_CYCLES): synchroniser plus glitch filter with a stable flag. Instantiated three times, for A, B and idx.
- The decoder, index logic and error counter stay in quad_decoder_ctrl.

Test Plan:
- Reset, then hold A=B=0 for 10 cycles -> primed=1; no count_enb, ld_cnt=1, err=0, err_cnt=0.
- Forward sequence 00,10,11,01,00, each level held 8 cycles -> exactly 4 count_enb pulses with updn_cnt=1; first pulse 6 edges after A rises (defaults).
- Reverse sequence 00,01,11,10,00 -> 4 pulses with updn_cnt=0; a 2-cycle glitch on B -> no pulse.
- Jump 00->11 in one step, repeated 300 times with 00 in between -> err=1, err_cnt=255, no count_enb during the illegal steps.
- idx_enb=1, preset=16'hA5A5, idx pulse 5 cycles wide in Q00 -> ld_cnt=0 for one cycle, data_in=16'hA5A5; the same pulse in Q11 -> no load.
- Index rise coinciding with an A edge producing a count -> ld_cnt=0, count_enb=0 that cycle; assert rst mid-sequence -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature decoder front end.
package quad_pkg;

  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_state_t;

  localparam logic       DIR_UP      = 1'b1;
  localparam logic       DIR_DN      = 1'b0;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // Successor of s when the encoder turns forward (A leads B).
  function automatic quad_state_t fwd_next(input quad_state_t s);
    quad_state_t n;
    case (s)
      Q00:     n = Q10;
      Q10:     n = Q11;
      Q11:     n = Q01;
      default: n = Q00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Synchroniser plus glitch filter for one asynchronous encoder pin.
module quad_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic stable
);

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(FILT_CYCLES - 1);
  localparam logic [CW-1:0] FULL = CW'(FILT_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          stab_cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];
  assign stable = (stab_cnt == FULL);

  // New level is accepted on the FILT_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '0;
      cnt      <= '0;
      stab_cnt <= '0;
      dout     <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      if (synced != dout) begin
        stab_cnt <= '0;
        if (cnt == LAST) begin
          dout <= synced;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
        if (stab_cnt != FULL) stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_decoder_ctrl.sv
// Quadrature decoder: filtered A/B/idx in, counter count/direction/load strobes out.
module quad_decoder_ctrl
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        quad_a,
  input  logic        quad_b,
  input  logic        quad_idx,
  input  logic        idx_enb,
  input  logic [15:0] preset,
  output logic        count_enb,
  output logic        updn_cnt,
  output logic        ld_cnt,
  output logic [15:0] data_in,
  output logic        err,
  output logic [7:0]  err_cnt
);

  logic a_filt, b_filt, idx_filt;
  logic a_stable, b_stable, idx_stable_unused;
  logic idx_prev, idx_rise, load;
  logic primed, primed_nxt;
  quad_state_t state, state_nxt, cur;
  logic [1:0]  diff;
  logic        count_nxt, dir_nxt, ld_nxt, err_nxt;
  logic [15:0] data_nxt;
  logic [7:0]  errcnt_nxt;

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_a (
    .clk(clk), .rst(rst), .din(quad_a), .dout(a_filt), .stable(a_stable)
  );
  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_b (
    .clk(clk), .rst(rst), .din(quad_b), .dout(b_filt), .stable(b_stable)
  );
  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_idx (
    .clk(clk), .rst(rst), .din(quad_idx), .dout(idx_filt), .stable(idx_stable_unused)
  );

  assign idx_rise = idx_filt & ~idx_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= Q00;
      primed    <= 1'b0;
      idx_prev  <= 1'b0;
      count_enb <= 1'b0;
      updn_cnt  <= DIR_UP;
      ld_cnt    <= 1'b1;
      data_in   <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      primed    <= primed_nxt;
      idx_prev  <= idx_filt;
      count_enb <= count_nxt;
      updn_cnt  <= dir_nxt;
      ld_cnt    <= ld_nxt;
      data_in   <= data_nxt;
      err       <= err_nxt;
      err_cnt   <= errcnt_nxt;
    end
  end

  // Load beats count: the state still tracks the encoder, only the strobe is dropped.
  always_comb begin
    state_nxt  = state;
    primed_nxt = primed;
    count_nxt  = 1'b0;
    dir_nxt    = updn_cnt;
    ld_nxt     = 1'b1;
    data_nxt   = data_in;
    err_nxt    = err;
    errcnt_nxt = err_cnt;
    cur        = quad_state_t'({a_filt, b_filt});
    diff       = cur ^ state;
    load       = 1'b0;
    if (!primed) begin
      if (a_stable && b_stable) begin
        state_nxt  = cur;
        primed_nxt = 1'b1;
      end
    end else begin
      load = idx_rise && idx_enb && (state == Q00);
      if (cur != state) begin
        state_nxt = cur;
        if (diff == 2'b11) begin
          err_nxt = 1'b1;
          if (err_cnt != ERR_CNT_MAX) errcnt_nxt = err_cnt + 8'd1;
        end else if (!load) begin
          count_nxt = 1'b1;
          dir_nxt   = (cur == fwd_next(state)) ? DIR_UP : DIR_DN;
        end
      end
      if (load) begin
        ld_nxt   = 1'b0;
        data_nxt = preset;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder_ctrl.sv
// Directed self-checking bench for quad_decoder_ctrl at default parameters.
module tb_quad_decoder_ctrl;

  logic        clk;
  logic        rst;
  logic        quad_a, quad_b, quad_idx, idx_enb;
  logic [15:0] preset;
  logic        count_enb, updn_cnt, ld_cnt, err;
  logic [15:0] data_in;
  logic [7:0]  err_cnt;

  int checks   = 0;
  int failures = 0;
  int pulses, ups, dns, loads;

  quad_decoder_ctrl dut (
    .clk(clk), .rst(rst), .quad_a(quad_a), .quad_b(quad_b), .quad_idx(quad_idx),
    .idx_enb(idx_enb), .preset(preset), .count_enb(count_enb), .updn_cnt(updn_cnt),
    .ld_cnt(ld_cnt), .data_in(data_in), .err(err), .err_cnt(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clearCounts();
    pulses = 0; ups = 0; dns = 0; loads = 0;
  endtask

  // Drive pins at a falling edge, then observe strobes on each following falling edge.
  task automatic applyStimulus(input logic a, input logic b, input logic idx, input int hold);
    quad_a = a; quad_b = b; quad_idx = idx;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (count_enb === 1'b1) begin
        pulses++;
        if (updn_cnt === 1'b1) ups++; else dns++;
      end
      if (ld_cnt === 1'b0) loads++;
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_count_enb"}, 16'(count_enb), 16'd0);
    checkOutput({tag, "_updn_cnt"},  16'(updn_cnt),  16'd1);
    checkOutput({tag, "_ld_cnt"},    16'(ld_cnt),    16'd1);
    checkOutput({tag, "_data_in"},   data_in,        16'h0000);
    checkOutput({tag, "_err"},       16'(err),       16'd0);
    checkOutput({tag, "_err_cnt"},   16'(err_cnt),   16'd0);
  endtask

  initial begin
    rst = 1'b1; quad_a = 1'b0; quad_b = 1'b0; quad_idx = 1'b0;
    idx_enb = 1'b0; preset = 16'h0000;
    repeat (3) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;

    $display("[TB] priming");
    clearCounts();
    applyStimulus(1'b0, 1'b0, 1'b0, 10);
    checkOutput("prime_primed", 16'(dut.primed), 16'd1);
    checkOutput("prime_pulses", 16'(pulses), 16'd0);
    checkOutput("prime_err", 16'(err), 16'd0);

    $display("[TB] forward sequence");
    quad_a = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("lat_before", 16'(count_enb), 16'd0);
    @(negedge clk);
    checkOutput("lat_pulse", 16'(count_enb), 16'd1);
    checkOutput("lat_dir", 16'(updn_cnt), 16'd1);
    clearCounts();
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 1'b0, 8);
    checkOutput("fwd_pulses", 16'(pulses), 16'd3);
    checkOutput("fwd_ups", 16'(ups), 16'd3);

    $display("[TB] reverse sequence and glitch");
    clearCounts();
    applyStimulus(1'b0, 1'b1, 1'b0, 8);
    applyStimulus(1'b1, 1'b1, 1'b0, 8);
    applyStimulus(1'b1, 1'b0, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 1'b0, 8);
    checkOutput("rev_pulses", 16'(pulses), 16'd4);
    checkOutput("rev_dns", 16'(dns), 16'd4);
    checkOutput("rev_dir_held", 16'(updn_cnt), 16'd0);
    clearCounts();
    applyStimulus(1'b0, 1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 10);
    checkOutput("glitch_pulses", 16'(pulses), 16'd0);

    $display("[TB] illegal transitions");
    clearCounts();
    applyStimulus(1'b1, 1'b1, 1'b0, 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 6);
    checkOutput("illegal_first_cnt", 16'(err_cnt), 16'd2);
    checkOutput("illegal_first_err", 16'(err), 16'd1);
    for (int i = 1; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 6);
      applyStimulus(1'b0, 1'b0, 1'b0, 6);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 4);
    checkOutput("illegal_sat_cnt", 16'(err_cnt), 16'd255);
    checkOutput("illegal_err", 16'(err), 16'd1);
    checkOutput("illegal_pulses", 16'(pulses), 16'd0);

    $display("[TB] index load");
    clearCounts();
    preset = 16'h1111;
    applyStimulus(1'b0, 1'b0, 1'b1, 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 8);
    checkOutput("idx_disabled_loads", 16'(loads), 16'd0);
    idx_enb = 1'b1;
    preset  = 16'hA5A5;
    clearCounts();
    applyStimulus(1'b0, 1'b0, 1'b1, 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 8);
    checkOutput("idx_q00_loads", 16'(loads), 16'd1);
    checkOutput("idx_q00_data", data_in, 16'hA5A5);
    preset = 16'h1234;
    applyStimulus(1'b1, 1'b0, 1'b0, 8);
    applyStimulus(1'b1, 1'b1, 1'b0, 8);
    clearCounts();
    applyStimulus(1'b1, 1'b1, 1'b1, 5);
    applyStimulus(1'b1, 1'b1, 1'b0, 8);
    checkOutput("idx_q11_loads", 16'(loads), 16'd0);
    checkOutput("idx_q11_data", data_in, 16'hA5A5);
    applyStimulus(1'b0, 1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 1'b0, 8);

    $display("[TB] load versus count");
    preset = 16'h5A5A;
    quad_a = 1'b1; quad_idx = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("coll_ld_cnt", 16'(ld_cnt), 16'd0);
    checkOutput("coll_count_enb", 16'(count_enb), 16'd0);
    checkOutput("coll_data", data_in, 16'h5A5A);
    clearCounts();
    applyStimulus(1'b1, 1'b0, 1'b0, 6);
    checkOutput("coll_after_pulses", 16'(pulses), 16'd0);
    checkOutput("coll_after_loads", 16'(loads), 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8);
    checkOutput("coll_back_dns", 16'(dns), 16'd1);

    $display("[TB] reset mid-sequence");
    quad_b = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkReset("midrst");
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
